// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA display engine.
//   - vga_mode_e   : output mode encodings (framebuffer, bars, solid, grid)
//   - BAR_*        : colour-bar flags as {R,G,B}, one bit per channel
//   - total_count  : line/frame period from active + porches + sync
//   - bar_flags    : colour of bar 0..7, left to right
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRID  = 2'd3
  } vga_mode_e;

  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic int total_count(input int active, input int front,
                                     input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    logic [2:0] f;
    case (idx)
      3'd0:    f = BAR_WHITE;
      3'd1:    f = BAR_YELLOW;
      3'd2:    f = BAR_CYAN;
      3'd3:    f = BAR_GREEN;
      3'd4:    f = BAR_MAGENTA;
      3'd5:    f = BAR_RED;
      3'd6:    f = BAR_BLUE;
      default: f = BAR_BLACK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster counters and their decodes.
//   clk, reset    : pixel clock, asynchronous active-high reset
//   enable        : low holds both counters at (0,0)
//   active        : inside visible area
//   image         : inside the scaled framebuffer image (clipped to active)
//   img_row       : current line lies inside the image
//   img_last_row  : current line is the last image line
//   hs_act/vs_act : sync interval (polarity applied by the caller)
//   frame_first   : counter at (0,0)
//   line_first    : h=0 on a visible line
//   line_last     : last pixel of a line; frame_last: last pixel of the frame
//   grid_on       : h[3:0]==0 or v[3:0]==0
// All decodes are combinational from the counters (stage 0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic active,
  output logic image,
  output logic img_row,
  output logic img_last_row,
  output logic hs_act,
  output logic vs_act,
  output logic frame_first,
  output logic line_first,
  output logic line_last,
  output logic frame_last,
  output logic grid_on
);

  localparam int H_TOTAL = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_CW    = $clog2(H_TOTAL + 1);
  localparam int V_CW    = $clog2(V_TOTAL + 1);

  localparam logic [H_CW-1:0] H_LAST    = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_ACT_END = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] H_IMG_END = H_CW'(IMG_W);
  localparam logic [H_CW-1:0] HS_START  = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] HS_END    = H_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST    = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_ACT_END = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] V_IMG_END = V_CW'(IMG_H);
  localparam logic [V_CW-1:0] V_IMG_LST = V_CW'(IMG_H - 1);
  localparam logic [V_CW-1:0] VS_START  = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] VS_END    = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CW-1:0] h_cnt;
  logic [V_CW-1:0] v_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active       = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign img_row      = (v_cnt < V_IMG_END);
  assign image        = (h_cnt < H_IMG_END) && img_row;
  assign img_last_row = (v_cnt == V_IMG_LST);
  assign hs_act       = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_act       = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign frame_first  = (h_cnt == '0) && (v_cnt == '0);
  assign line_first   = (h_cnt == '0) && (v_cnt < V_ACT_END);
  assign line_last    = (h_cnt == H_LAST);
  assign frame_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign grid_on      = (h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0);

endmodule

// File: rtl/vga_display_engine.sv
// vga_display_engine: configurable VGA timing, framebuffer fetch with
// integer up-scaling, and built-in test patterns.
//   clk, reset            : pixel clock, asynchronous active-high reset
//   enable                : low idles the engine and restarts at (0,0)
//   mode                  : 0 framebuffer, 1 colour bars, 2 solid, 3 grid
//   border_rgb            : colour outside the image and for mode 2, {R,G,B}
//   fb_rd_en, fb_addr     : framebuffer read request (combinational, stage 0)
//   fb_rdata              : read data, valid RD_LATENCY cycles after request
//   vga_r/g/b, hsync,
//   vsync, frame_start,
//   line_start            : registered pin outputs, RD_LATENCY+1 cycles
//                           after the counter cycle they describe
module vga_display_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_W    = 4,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int SCALE_LOG2 = 1,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   border_rgb,
  output logic                   fb_rd_en,
  output logic [ADDR_W-1:0]      fb_addr,
  input  logic [3*COLOR_W-1:0]   fb_rdata,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   line_start
);

  localparam int RGB_W     = 3 * COLOR_W;
  localparam int PW        = RGB_W + 5;
  localparam int IMG_W_RAW = FB_W << SCALE_LOG2;
  localparam int IMG_H_RAW = FB_H << SCALE_LOG2;
  localparam int IMG_W     = (IMG_W_RAW < H_ACTIVE) ? IMG_W_RAW : H_ACTIVE;
  localparam int IMG_H     = (IMG_H_RAW < V_ACTIVE) ? IMG_H_RAW : V_ACTIVE;
  localparam int BAR_W     = H_ACTIVE / 8;

  localparam logic              HS_ON       = 1'(HSYNC_POL);
  localparam logic              VS_ON       = 1'(VSYNC_POL);
  localparam logic [7:0]        SUB_MAX     = 8'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] FB_STRIDE   = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] FB_LAST_COL = ADDR_W'(FB_W - 1);
  localparam logic [15:0]       BAR_LAST    = 16'(BAR_W - 1);
  // Pipeline word: {use_fb, hsync, vsync, frame_start, line_start, rgb}
  localparam logic [PW-1:0]     IDLE_WORD   = {1'b0, ~HS_ON, ~VS_ON, 2'b00, {RGB_W{1'b0}}};

  function automatic logic [RGB_W-1:0] expand_rgb(input logic [2:0] f);
    return {{COLOR_W{f[2]}}, {COLOR_W{f[1]}}, {COLOR_W{f[0]}}};
  endfunction

  logic active, image, img_row, img_last_row, hs_act, vs_act;
  logic frame_first, line_first, line_last, frame_last, grid_on;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .IMG_W    (IMG_W),    .IMG_H (IMG_H)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .active       (active),
    .image        (image),
    .img_row      (img_row),
    .img_last_row (img_last_row),
    .hs_act       (hs_act),
    .vs_act       (vs_act),
    .frame_first  (frame_first),
    .line_first   (line_first),
    .line_last    (line_last),
    .frame_last   (frame_last),
    .grid_on      (grid_on)
  );

  // ---- stage 0: counter cycle, mode, address, pattern ----
  logic             vld_p0;
  vga_mode_e        mode_q, mode_p0;
  logic [ADDR_W-1:0] line_base, col_addr;
  logic [7:0]       h_sub, v_sub;
  logic [15:0]      bar_px;
  logic [2:0]       bar_idx;
  logic [RGB_W-1:0] rgb_p0;
  logic             use_fb_p0, hs_p0, vs_p0, fs_p0, ls_p0;
  logic [PW-1:0]    word_p0;

  // Reset is folded in so the read strobe is quiet while reset is held.
  assign vld_p0 = enable && !reset;

  // The frame's mode is taken at (0,0) and applies from that pixel on.
  assign mode_p0 = frame_first ? vga_mode_e'(mode) : mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mode_q <= MODE_FB;
    else if (!enable) mode_q <= MODE_FB;
    else              mode_q <= mode_p0;
  end

  // Incremental raster address: column steps every 2^S pixels, line base
  // steps by FB_W every 2^S image lines. Both saturate at the last
  // framebuffer pixel so the address stays in range outside the image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_base <= '0;
      col_addr  <= '0;
      h_sub     <= '0;
      v_sub     <= '0;
    end else if (!enable) begin
      line_base <= '0;
      col_addr  <= '0;
      h_sub     <= '0;
      v_sub     <= '0;
    end else if (line_last) begin
      col_addr <= '0;
      h_sub    <= '0;
      if (frame_last) begin
        line_base <= '0;
        v_sub     <= '0;
      end else if (img_row) begin
        if (v_sub == SUB_MAX) begin
          v_sub <= '0;
          if (!img_last_row) line_base <= line_base + FB_STRIDE;
        end else begin
          v_sub <= v_sub + 8'd1;
        end
      end
    end else if (image) begin
      if (h_sub == SUB_MAX) begin
        h_sub <= '0;
        if (col_addr != FB_LAST_COL) col_addr <= col_addr + 1'b1;
      end else begin
        h_sub <= h_sub + 8'd1;
      end
    end
  end

  // Bar index advances every BAR_W visible pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!enable || line_last) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (active) begin
      if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + 16'd1;
      end
    end
  end

  always_comb begin
    rgb_p0    = '0;
    use_fb_p0 = 1'b0;
    if (vld_p0 && active) begin
      if (!image) begin
        rgb_p0 = border_rgb;
      end else begin
        case (mode_p0)
          MODE_FB:    use_fb_p0 = 1'b1;
          MODE_BARS:  rgb_p0 = expand_rgb(bar_flags(bar_idx));
          MODE_SOLID: rgb_p0 = border_rgb;
          MODE_GRID:  rgb_p0 = {RGB_W{grid_on}};
          default:    rgb_p0 = '0;
        endcase
      end
    end
  end

  assign hs_p0   = (vld_p0 && hs_act) ? HS_ON : ~HS_ON;
  assign vs_p0   = (vld_p0 && vs_act) ? VS_ON : ~VS_ON;
  assign fs_p0   = vld_p0 && frame_first;
  assign ls_p0   = vld_p0 && line_first;
  assign word_p0 = {use_fb_p0, hs_p0, vs_p0, fs_p0, ls_p0, rgb_p0};

  assign fb_rd_en = use_fb_p0;
  assign fb_addr  = line_base + col_addr;

  // ---- stage 1..RD_LATENCY: delay matching the framebuffer read ----
  logic [PW-1:0] dly_p [RD_LATENCY];
  logic [PW-1:0] word_pl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) dly_p[i] <= IDLE_WORD;
    end else begin
      dly_p[0] <= word_p0;
      for (int i = 1; i < RD_LATENCY; i++) dly_p[i] <= dly_p[i-1];
    end
  end

  assign word_pl = dly_p[RD_LATENCY-1];

  // ---- output register: merge framebuffer data, drive pins ----
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      rgb_q       <= word_pl[PW-1] ? fb_rdata : word_pl[RGB_W-1:0];
      hsync       <= word_pl[PW-2];
      vsync       <= word_pl[PW-3];
      frame_start <= word_pl[PW-4];
      line_start  <= word_pl[PW-5];
    end
  end

  assign vga_r = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b = rgb_q[COLOR_W-1:0];

endmodule
